// File: rtl/tensor_loader_pkg.sv
// Shared types and size helpers for the 3D tensor loader and its index generator.
package tensor_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_e;

  typedef enum logic {
    ORDER_DHW = 1'b0,
    ORDER_HWD = 1'b1
  } load_order_e;

  function automatic int calc_total(input int depth, input int height, input int width);
    return depth * height * width;
  endfunction

  function automatic int calc_beats(input int depth, input int height, input int width,
                                    input int lanes);
    return calc_total(depth, height, width) / lanes;
  endfunction

  // Index registers stay at least one bit wide so a unit dimension still elaborates.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/loader_index_gen.sv
// Base (d,h,w) walker for one beat of LANES elements; advances one beat per step, 1-cycle update.
// Never wraps past the final beat: it parks there with last high until cleared.
module loader_index_gen
  import tensor_loader_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int HEIGHT = 8,
  parameter int WIDTH  = 8,
  parameter int LANES  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         step,
  input  load_order_e                  order,
  output logic [idx_width(DEPTH)-1:0]  base_d,
  output logic [idx_width(HEIGHT)-1:0] base_h,
  output logic [idx_width(WIDTH)-1:0]  base_w,
  output logic                         last
);

  localparam int DW = idx_width(DEPTH);
  localparam int HW = idx_width(HEIGHT);
  localparam int WW = idx_width(WIDTH);

  localparam logic [DW-1:0] D_MAX  = DW'(DEPTH - 1);
  localparam logic [DW-1:0] D_BASE = DW'(DEPTH - LANES);
  localparam logic [HW-1:0] H_MAX  = HW'(HEIGHT - 1);
  localparam logic [WW-1:0] W_MAX  = WW'(WIDTH - 1);
  localparam logic [WW-1:0] W_BASE = WW'(WIDTH - LANES);

  logic [DW-1:0] d_n;
  logic [HW-1:0] h_n;
  logic [WW-1:0] w_n;

  always_comb begin
    last = 1'b0;
    if (order == ORDER_DHW) begin
      last = (base_d == D_MAX) && (base_h == H_MAX) && (base_w == W_BASE);
    end else begin
      last = (base_h == H_MAX) && (base_w == W_MAX) && (base_d == D_BASE);
    end
  end

  always_comb begin
    d_n = base_d;
    h_n = base_h;
    w_n = base_w;
    if (step && !last) begin
      if (order == ORDER_DHW) begin
        if (base_w == W_BASE) begin
          w_n = '0;
          if (base_h == H_MAX) begin
            h_n = '0;
            d_n = base_d + DW'(1);
          end else begin
            h_n = base_h + HW'(1);
          end
        end else begin
          w_n = base_w + WW'(LANES);
        end
      end else begin
        if (base_d == D_BASE) begin
          d_n = '0;
          if (base_w == W_MAX) begin
            w_n = '0;
            h_n = base_h + HW'(1);
          end else begin
            w_n = base_w + WW'(1);
          end
        end else begin
          d_n = base_d + DW'(LANES);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      base_d <= '0;
      base_h <= '0;
      base_w <= '0;
    end else begin
      base_d <= d_n;
      base_h <= h_n;
      base_w <= w_n;
    end
  end

endmodule

// File: rtl/tensor_loader_3d.sv
// Scatters a valid/ready stream of LANES-wide beats into a registered DEPTH x HEIGHT x WIDTH tensor.
// Writes land on the accepting edge; in_ready is high only while loading, so FULL applies backpressure.
module tensor_loader_3d
  import tensor_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 8,
  parameter int HEIGHT         = 8,
  parameter int WIDTH          = 8,
  parameter int LANES          = 1,
  parameter int CLEAR_ON_START = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   order,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]            in_data,
  output logic                                   busy,
  output logic                                   done,
  output logic [count_width(calc_beats(DEPTH, HEIGHT, WIDTH, LANES))-1:0] beat_count,
  output logic signed [DATA_WIDTH-1:0]           tensor_out [DEPTH][HEIGHT][WIDTH]
);

  localparam int BEATS = calc_beats(DEPTH, HEIGHT, WIDTH, LANES);
  localparam int BCW   = count_width(BEATS);
  localparam int DW    = idx_width(DEPTH);
  localparam int HW    = idx_width(HEIGHT);
  localparam int WW    = idx_width(WIDTH);

  if (((WIDTH % LANES) != 0) || ((DEPTH % LANES) != 0)) begin : g_lanes_check
    $error("tensor_loader_3d: LANES must divide both WIDTH and DEPTH");
  end

  loader_state_e state_q, state_d;
  load_order_e   order_q;
  logic [BCW-1:0] beat_q;
  logic [DW-1:0]  base_d;
  logic [HW-1:0]  base_h;
  logic [WW-1:0]  base_w;
  logic           last;
  logic           xfer;
  logic           step;

  logic [DW-1:0] lane_d [LANES];
  logic [HW-1:0] lane_h [LANES];
  logic [WW-1:0] lane_w [LANES];

  assign in_ready   = (state_q == LOAD);
  assign busy       = (state_q == LOAD);
  assign done       = (state_q == FULL);
  assign beat_count = beat_q;

  // A start in the same cycle as a transfer wins: the beat is dropped.
  assign xfer = in_valid && in_ready;
  assign step = xfer && !start;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = LOAD;
    end else if (step && last) begin
      state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      order_q <= ORDER_DHW;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        order_q <= load_order_e'(order);
        beat_q  <= '0;
      end else if (step) begin
        beat_q <= beat_q + BCW'(1);
      end
    end
  end

  loader_index_gen #(
    .DEPTH  (DEPTH),
    .HEIGHT (HEIGHT),
    .WIDTH  (WIDTH),
    .LANES  (LANES)
  ) u_index_gen (
    .clk    (clk),
    .rst    (rst),
    .clear  (start),
    .step   (step),
    .order  (order_q),
    .base_d (base_d),
    .base_h (base_h),
    .base_w (base_w),
    .last   (last)
  );

  // Lanes fan out along w for D-H-W order and along d for H-W-D order.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_d[k] = base_d;
      lane_h[k] = base_h;
      lane_w[k] = base_w;
      if (order_q == ORDER_DHW) begin
        lane_w[k] = base_w + WW'(k);
      end else begin
        lane_d[k] = base_d + DW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < HEIGHT; j++)
          for (int l = 0; l < WIDTH; l++)
            tensor_out[i][j][l] <= '0;
    end else if (start) begin
      if (CLEAR_ON_START != 0) begin
        for (int i = 0; i < DEPTH; i++)
          for (int j = 0; j < HEIGHT; j++)
            for (int l = 0; l < WIDTH; l++)
              tensor_out[i][j][l] <= '0;
      end
    end else if (step) begin
      for (int k = 0; k < LANES; k++) begin
        tensor_out[lane_d[k]][lane_h[k]][lane_w[k]] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tensor_loader_3d.sv
// Two loaders (1 lane / clear-on-start, 4 lanes / retain) checked every cycle against an element-order model.
module tb_tensor_loader_3d;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: defaults (LANES=1, CLEAR_ON_START=1)
  logic        rst_a = 1'b1, start_a = 1'b0, order_a = 1'b0, valid_a = 1'b0;
  logic [31:0] data_a = '0;
  logic        ready_a, busy_a, done_a;
  logic [9:0]  bc_a;
  logic signed [31:0] t_a [8][8][8];

  // Instance B: LANES=4, CLEAR_ON_START=0
  logic         rst_b = 1'b1, start_b = 1'b0, order_b = 1'b0, valid_b = 1'b0;
  logic [127:0] data_b = '0;
  logic         ready_b, busy_b, done_b;
  logic [7:0]   bc_b;
  logic signed [31:0] t_b [8][8][8];

  tensor_loader_3d u_dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .order(order_a),
    .in_valid(valid_a), .in_ready(ready_a), .in_data(data_a),
    .busy(busy_a), .done(done_a), .beat_count(bc_a), .tensor_out(t_a)
  );

  tensor_loader_3d #(.LANES(4), .CLEAR_ON_START(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .order(order_b),
    .in_valid(valid_b), .in_ready(ready_b), .in_data(data_b),
    .busy(busy_b), .done(done_b), .beat_count(bc_b), .tensor_out(t_b)
  );

  // Model: 0 idle, 1 loading, 2 full; tensor flat at d*64+h*8+w.
  int m_t     [2][512];
  int m_state [2];
  int m_beats [2];
  int m_ord   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_beats[i] = 0; m_ord[i] = 0;
      for (int e = 0; e < 512; e++) m_t[i][e] = 0;
    end
  end

  task automatic model_edge(input int i, input bit r, input bit s, input bit o, input bit v,
                            input logic [127:0] dat);
    int lanes, e, d, h, w;
    lanes = (i == 0) ? 1 : 4;
    if (r) begin
      m_state[i] = 0; m_beats[i] = 0;
      for (int x = 0; x < 512; x++) m_t[i][x] = 0;
    end else if (s) begin
      m_state[i] = 1; m_beats[i] = 0; m_ord[i] = int'(o);
      if (i == 0) for (int x = 0; x < 512; x++) m_t[i][x] = 0;
    end else if (m_state[i] == 1 && v) begin
      for (int k = 0; k < lanes; k++) begin
        e = m_beats[i] * lanes + k;
        if (m_ord[i] == 0) begin
          d = e / 64; h = (e / 8) % 8; w = e % 8;
        end else begin
          h = e / 64; w = (e / 8) % 8; d = e % 8;
        end
        m_t[i][d*64 + h*8 + w] = int'(dat[k*32 +: 32]);
      end
      m_beats[i] = m_beats[i] + 1;
      if (m_beats[i] == 512 / lanes) m_state[i] = 2;
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, rst_a, start_a, order_a, valid_a, {96'b0, data_a});
    model_edge(1, rst_b, start_b, order_b, valid_b, data_b);
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int bad_a, bad_b, first_a, first_b;
    bad_a = 0; bad_b = 0; first_a = -1; first_b = -1;
    chk("a_in_ready", int'(ready_a), int'(m_state[0] == 1));
    chk("a_busy", int'(busy_a), int'(m_state[0] == 1));
    chk("a_done", int'(done_a), int'(m_state[0] == 2));
    chk("a_beat_count", int'(bc_a), m_beats[0]);
    chk("b_in_ready", int'(ready_b), int'(m_state[1] == 1));
    chk("b_busy", int'(busy_b), int'(m_state[1] == 1));
    chk("b_done", int'(done_b), int'(m_state[1] == 2));
    chk("b_beat_count", int'(bc_b), m_beats[1]);
    for (int d = 0; d < 8; d++)
      for (int h = 0; h < 8; h++)
        for (int w = 0; w < 8; w++) begin
          if (int'(t_a[d][h][w]) != m_t[0][d*64+h*8+w]) begin
            bad_a++; if (first_a < 0) first_a = d*64+h*8+w;
          end
          if (int'(t_b[d][h][w]) != m_t[1][d*64+h*8+w]) begin
            bad_b++; if (first_b < 0) first_b = d*64+h*8+w;
          end
        end
    chk($sformatf("a_tensor_bad_elems(first=%0d)", first_a), bad_a, 0);
    chk($sformatf("b_tensor_bad_elems(first=%0d)", first_b), bad_b, 0);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse(input int i, input bit o);
    if (i == 0) begin start_a = 1'b1; order_a = o; end
    else        begin start_b = 1'b1; order_b = o; end
    cyc();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Feed until the model has accepted target beats; rnd selects random payloads.
  task automatic feed(input int i, input int target, input int idle_pct, input bit rnd);
    for (int c = 0; c < 20000 && m_beats[i] < target && m_state[i] == 1; c++) begin
      if (i == 0) begin
        valid_a = ($urandom_range(0, 99) >= idle_pct);
        data_a  = rnd ? $urandom : m_beats[0];
      end else begin
        valid_b = ($urandom_range(0, 99) >= idle_pct);
        for (int k = 0; k < 4; k++)
          data_b[k*32 +: 32] = rnd ? $urandom : 4 * m_beats[1] + k;
      end
      cyc();
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (m_beats[i] < target) begin
      tests++;
      fails++;
      $display("FAIL feed_timeout: dut %0d reached %0d beats, required %0d", i, m_beats[i], target);
    end
  endtask

  initial begin
    cyc(); cyc();
    rst_a = 1'b0; rst_b = 1'b0;
    chk("lit_rst_busy", int'(busy_a), 0);
    chk("lit_rst_beat_count", int'(bc_a), 0);
    chk("lit_rst_elem", int'(t_a[4][4][4]), 0);

    // A: order 0, values 0..511 back-to-back
    start_pulse(0, 1'b0);
    feed(0, 512, 0, 1'b0);
    cyc();
    chk("lit_a_done", int'(done_a), 1);
    chk("lit_a_beat_count", int'(bc_a), 512);
    chk("lit_a_elem_3_5_7", int'(t_a[3][5][7]), 239);
    chk("lit_a_elem_7_7_7", int'(t_a[7][7][7]), 511);

    // A: same data with random idle cycles
    start_pulse(0, 1'b0);
    feed(0, 512, 30, 1'b0);
    cyc();
    chk("lit_gap_elem_3_5_7", int'(t_a[3][5][7]), 239);
    chk("lit_gap_elem_0_1_0", int'(t_a[0][1][0]), 8);

    // A: start collides with beat 100
    start_pulse(0, 1'b0);
    feed(0, 100, 0, 1'b0);
    start_a = 1'b1; valid_a = 1'b1; data_a = 32'hDEAD;
    cyc();
    start_a = 1'b0; valid_a = 1'b0;
    chk("lit_clear_elem_1_0_2", int'(t_a[1][0][2]), 0);
    chk("lit_clear_beat_count", int'(bc_a), 0);
    chk("lit_clear_in_ready", int'(ready_a), 1);
    feed(0, 512, 20, 1'b1);
    cyc();
    chk("lit_refill_done", int'(done_a), 1);

    // A: rst beats a simultaneous start
    rst_a = 1'b1; start_a = 1'b1;
    cyc();
    rst_a = 1'b0; start_a = 1'b0;
    chk("lit_rst_start_busy", int'(busy_a), 0);
    chk("lit_rst_start_ready", int'(ready_a), 0);
    cyc();
    chk("lit_rst_start_idle", int'(busy_a), 0);

    // B: 4 lanes, order 1, then extra beats while full
    start_pulse(1, 1'b1);
    feed(1, 128, 0, 1'b0);
    valid_b = 1'b1; data_b = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) cyc();
    valid_b = 1'b0;
    chk("lit_b_ready_full", int'(ready_b), 0);
    chk("lit_b_done", int'(done_b), 1);
    chk("lit_b_beat_count", int'(bc_b), 128);
    chk("lit_b_elem_2_3_4", int'(t_b[2][3][4]), 226);
    chk("lit_b_elem_0_0_1", int'(t_b[0][0][1]), 8);

    // B: frame aborted by rst
    start_pulse(1, 1'b0);
    feed(1, 10, 0, 1'b1);
    rst_b = 1'b1;
    cyc();
    rst_b = 1'b0;
    chk("lit_b_rst_done", int'(done_b), 0);
    chk("lit_b_rst_elem", int'(t_b[2][3][4]), 0);
    chk("lit_b_rst_beat_count", int'(bc_b), 0);

    // B: frame aborted by start keeps untouched prior values
    start_pulse(1, 1'b1);
    feed(1, 128, 0, 1'b0);
    start_pulse(1, 1'b1);
    feed(1, 10, 0, 1'b1);
    start_b = 1'b1; valid_b = 1'b1;
    cyc();
    start_b = 1'b0; valid_b = 1'b0;
    chk("lit_b_keep_7_7_7", int'(t_b[7][7][7]), 511);
    chk("lit_b_keep_2_3_4", int'(t_b[2][3][4]), 226);
    chk("lit_b_restart_count", int'(bc_b), 0);
    feed(1, 128, 30, 1'b1);
    cyc();
    chk("lit_b_final_done", int'(done_b), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
